// File: rtl/bt_cmd_decoder.sv
// bt_cmd_decoder: turns UART command bytes into jump/restart strobes and a pause level,
// with a rate-limited jump queue. Define BT_CMD_FRAMING_EN for '#'-prefixed framing with timeout.
module bt_cmd_decoder #(
    parameter int HOLDOFF_CYCLES = 2_500_000,
    parameter int PEND_MAX       = 3,
    parameter int FRAME_TIMEOUT  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       jump_pulse,
    output logic       restart_pulse,
    output logic       paused,
    output logic [2:0] pend_cnt,
    output logic [7:0] err_cnt
);

    localparam int HOLD_W = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [2:0] PEND_LIMIT = 3'(PEND_MAX);

    localparam int N_JUMP  = 3;
    localparam int N_PAIR  = 2;
    localparam logic [N_JUMP*8-1:0] JUMP_CODES    = {8'h31, 8'h6A, 8'h4A};
    localparam logic [N_PAIR*8-1:0] RESTART_CODES = {8'h72, 8'h52};
    localparam logic [N_PAIR*8-1:0] PAUSE_CODES   = {8'h70, 8'h50};

    if (PEND_MAX < 1 || PEND_MAX > 7 || HOLDOFF_CYCLES < 1 || FRAME_TIMEOUT < 1) begin : g_param_check
        $error("bt_cmd_decoder: parameter out of range");
    end

    // ------------------------------------------------------------------
    // rx_done synchronizer, rising-edge detect and byte capture
    // ------------------------------------------------------------------
    logic       s0_reg;
    logic       s1_reg;
    logic       byte_edge;
    logic [7:0] byte_reg;
    logic       byte_valid_reg;

    assign byte_edge = s0_reg & ~s1_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_reg         <= 1'b0;
            s1_reg         <= 1'b0;
            byte_reg       <= 8'h00;
            byte_valid_reg <= 1'b0;
        end else begin
            s0_reg         <= rx_done;
            s1_reg         <= s0_reg;
            byte_valid_reg <= byte_edge;
            if (byte_edge) begin
                byte_reg <= rx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command classification
    // ------------------------------------------------------------------
    logic [N_JUMP-1:0] jump_hit;
    logic [N_PAIR-1:0] restart_hit;
    logic [N_PAIR-1:0] pause_hit;
    logic              code_jump;
    logic              code_restart;
    logic              code_pause;
    logic              code_null;
    logic              code_unknown;

    genvar gi;
    generate
        for (gi = 0; gi < N_JUMP; gi++) begin : g_jump
            assign jump_hit[gi] = (byte_reg == JUMP_CODES[gi*8 +: 8]);
        end
        for (gi = 0; gi < N_PAIR; gi++) begin : g_restart
            assign restart_hit[gi] = (byte_reg == RESTART_CODES[gi*8 +: 8]);
        end
        for (gi = 0; gi < N_PAIR; gi++) begin : g_pause
            assign pause_hit[gi] = (byte_reg == PAUSE_CODES[gi*8 +: 8]);
        end
    endgenerate

    assign code_jump    = |jump_hit;
    assign code_restart = |restart_hit;
    assign code_pause   = |pause_hit;
    assign code_null    = (byte_reg == 8'h00);
    assign code_unknown = ~(code_jump | code_restart | code_pause | code_null);

    // ------------------------------------------------------------------
    // Optional framing: only the byte following '#' is treated as a command
    // ------------------------------------------------------------------
    logic cmd_valid;
    logic frame_timeout;

`ifdef BT_CMD_FRAMING_EN
    localparam int TMO_W = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TIMEOUT - 1);

    typedef enum logic {
        WAIT_HDR = 1'b0,
        WAIT_CMD = 1'b1
    } frame_state_t;

    frame_state_t     frame_state_reg;
    frame_state_t     frame_state_next;
    logic [TMO_W-1:0] frame_tmr_reg;
    logic [TMO_W-1:0] frame_tmr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_state_reg <= WAIT_HDR;
            frame_tmr_reg   <= '0;
        end else begin
            frame_state_reg <= frame_state_next;
            frame_tmr_reg   <= frame_tmr_next;
        end
    end

    always_comb begin
        frame_state_next = frame_state_reg;
        frame_tmr_next   = frame_tmr_reg;
        frame_timeout    = 1'b0;
        cmd_valid        = 1'b0;
        case (frame_state_reg)
            WAIT_HDR: begin
                if (byte_valid_reg && byte_reg == 8'h23) begin
                    frame_state_next = WAIT_CMD;
                    frame_tmr_next   = '0;
                end
            end
            WAIT_CMD: begin
                if (byte_valid_reg) begin
                    cmd_valid        = 1'b1;
                    frame_state_next = WAIT_HDR;
                end else if (frame_tmr_reg == TMO_LAST) begin
                    frame_timeout    = 1'b1;
                    frame_state_next = WAIT_HDR;
                end else begin
                    frame_tmr_next = frame_tmr_reg + 1'b1;
                end
            end
            default: begin
                frame_state_next = WAIT_HDR;
            end
        endcase
    end
`else
    assign cmd_valid     = byte_valid_reg;
    assign frame_timeout = 1'b0;
`endif

    logic jump_req;
    logic restart_evt;
    logic pause_toggle;
    logic unknown_evt;

    assign jump_req     = cmd_valid & code_jump;
    assign restart_evt  = cmd_valid & code_restart;
    assign pause_toggle = cmd_valid & code_pause;
    assign unknown_evt  = cmd_valid & code_unknown;

    // ------------------------------------------------------------------
    // Jump scheduler: issue one queued jump, then hold off
    // ------------------------------------------------------------------
    typedef enum logic {
        READY = 1'b0,
        HOLD  = 1'b1
    } sched_state_t;

    sched_state_t      sched_state_reg;
    sched_state_t      sched_state_next;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              issue;
    logic [2:0]        pend_cnt_reg;
    logic [2:0]        pend_cnt_next;
    logic              paused_reg;
    logic              paused_next;
    logic [7:0]        err_cnt_reg;
    logic [7:0]        err_cnt_next;
    logic              jump_pulse_reg;
    logic              restart_pulse_reg;
    logic              req_ok;
    logic              req_drop;
    logic              err_inc;

    always_comb begin
        sched_state_next = sched_state_reg;
        hold_cnt_next    = hold_cnt_reg;
        issue            = 1'b0;
        case (sched_state_reg)
            READY: begin
                if (pend_cnt_reg != 3'd0 && !paused_reg) begin
                    issue = 1'b1;
                    if (HOLDOFF_CYCLES > 1) begin
                        sched_state_next = HOLD;
                        hold_cnt_next    = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                // Leaving as the counter reaches zero keeps issues exactly HOLDOFF_CYCLES apart
                if (hold_cnt_reg <= HOLD_W'(1)) begin
                    sched_state_next = READY;
                end
                if (hold_cnt_reg != '0) begin
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                end
            end
            default: begin
                sched_state_next = READY;
            end
        endcase
        if (restart_evt) begin
            sched_state_next = READY;
            hold_cnt_next    = '0;
            issue            = 1'b0;
        end
    end

    always_comb begin
        req_ok   = jump_req & (pend_cnt_reg < PEND_LIMIT);
        req_drop = jump_req & (pend_cnt_reg >= PEND_LIMIT);
        err_inc  = unknown_evt | req_drop | frame_timeout;

        err_cnt_next = err_cnt_reg;
        if (err_inc && err_cnt_reg != 8'hFF) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end

        if (restart_evt) begin
            pend_cnt_next = 3'd0;
            paused_next   = 1'b0;
        end else begin
            pend_cnt_next = pend_cnt_reg + {2'b00, req_ok} - {2'b00, issue};
            paused_next   = paused_reg ^ pause_toggle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sched_state_reg   <= READY;
            hold_cnt_reg      <= '0;
            pend_cnt_reg      <= 3'd0;
            paused_reg        <= 1'b0;
            err_cnt_reg       <= 8'h00;
            jump_pulse_reg    <= 1'b0;
            restart_pulse_reg <= 1'b0;
        end else begin
            sched_state_reg   <= sched_state_next;
            hold_cnt_reg      <= hold_cnt_next;
            pend_cnt_reg      <= pend_cnt_next;
            paused_reg        <= paused_next;
            err_cnt_reg       <= err_cnt_next;
            jump_pulse_reg    <= issue;
            restart_pulse_reg <= restart_evt;
        end
    end

    assign jump_pulse    = jump_pulse_reg;
    assign restart_pulse = restart_pulse_reg;
    assign paused        = paused_reg;
    assign pend_cnt      = pend_cnt_reg;
    assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Testbench for bt_cmd_decoder: directed scenarios plus randomized byte traffic,
// all outputs compared every cycle against a time-based behavioural model.
`timescale 1ns/1ps
module tb_bt_cmd_decoder;

    localparam int HOLDOFF = 8;
    localparam int PMAX    = 3;
    localparam int FTMO    = 20;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       jump_pulse;
    logic       restart_pulse;
    logic       paused;
    logic [2:0] pend_cnt;
    logic [7:0] err_cnt;

    bt_cmd_decoder #(
        .HOLDOFF_CYCLES(HOLDOFF),
        .PEND_MAX      (PMAX),
        .FRAME_TIMEOUT (FTMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .jump_pulse   (jump_pulse),
        .restart_pulse(restart_pulse),
        .paused       (paused),
        .pend_cnt     (pend_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int jump_times[$];
    int restart_times[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a byte takes effect two edges after its rx_done rise
    // is first sampled; jumps are spaced by absolute time, not a counter FSM.
    // ------------------------------------------------------------------
    bit       m_prev, m_det, m_have;
    bit [7:0] m_byte;
    int       m_pend, m_err, m_next_ok;
    bit       m_paused, m_jump, m_restart;
    bit       m_in_cmd;
    int       m_deadline;

    task automatic classify(input bit [7:0] b, output bit j, output bit r, output bit p, output bit e);
        j = 0; r = 0; p = 0; e = 0;
        case (b)
            8'h4A, 8'h6A, 8'h31: j = 1;
            8'h52, 8'h72:        r = 1;
            8'h50, 8'h70:        p = 1;
            8'h00:               ;
            default:             e = 1;
        endcase
    endtask

    task automatic model_step();
        bit dec, j, r, p, e, issue;
        bit [7:0] b;
        if (reset) begin
            m_prev = 0; m_det = 0; m_have = 0; m_byte = 0;
            m_pend = 0; m_err = 0; m_next_ok = 0; m_paused = 0;
            m_jump = 0; m_restart = 0; m_in_cmd = 0; m_deadline = 0;
            return;
        end
        dec = m_have;
        b   = m_byte;
        m_have = m_det;
        if (m_det) m_byte = rx_data;
        m_det  = rx_done && !m_prev;
        m_prev = rx_done;

        j = 0; r = 0; p = 0; e = 0;
`ifdef BT_CMD_FRAMING_EN
        if (m_in_cmd) begin
            if (dec) begin
                classify(b, j, r, p, e);
                m_in_cmd = 0;
            end else if (cyc == m_deadline) begin
                e = 1;
                m_in_cmd = 0;
            end
        end else if (dec && b == 8'h23) begin
            m_in_cmd   = 1;
            m_deadline = cyc + FTMO;
        end
`else
        if (dec) classify(b, j, r, p, e);
`endif

        issue = (m_pend > 0) && !m_paused && (cyc >= m_next_ok);
        if (r) begin
            m_pend = 0; m_paused = 0; m_next_ok = 0;
            m_jump = 0; m_restart = 1;
        end else begin
            m_restart = 0;
            m_jump    = issue;
            if (issue) m_next_ok = cyc + HOLDOFF;
            if (j) begin
                if (m_pend < PMAX) m_pend++;
                else e = 1;
            end
            if (issue) m_pend--;
            if (p) m_paused = !m_paused;
        end
        if (e && m_err < 255) m_err++;
    endtask

    always begin
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        if (jump_pulse === 1'b1) jump_times.push_back(cyc);
        if (restart_pulse === 1'b1) restart_times.push_back(cyc);
        chk("jump_pulse", int'(jump_pulse), int'(m_jump));
        chk("restart_pulse", int'(restart_pulse), int'(m_restart));
        chk("paused", int'(paused), int'(m_paused));
        chk("pend_cnt", int'(pend_cnt), m_pend);
        chk("err_cnt", int'(err_cnt), m_err);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // ------------------------------------------------------------------
    task automatic send(input bit [7:0] b, input int hi, input int lo, input bit scramble, output int k);
        rx_data = b;
        rx_done = 1'b1;
        k = cyc + 1;
        for (int j = 0; j < hi; j++) begin
            @(negedge clk);
            if (j == 1 && scramble) rx_data = 8'($urandom);
        end
        rx_done = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1000000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, k0, ka, k4;
        bit [7:0] b;
        int r;
        idle(3);
        chk("rst_jump", int'(jump_pulse), 0);
        chk("rst_restart", int'(restart_pulse), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_pend", int'(pend_cnt), 0);
        chk("rst_err", int'(err_cnt), 0);
        reset = 1'b0;
        idle(2);

`ifndef BT_CMD_FRAMING_EN
        // single jump: strobe three cycles after rx_done is first sampled
        jump_times.delete();
        send(8'h4A, 1, 1, 0, k);
        wait_cyc(k + 12);
        chk("sc1_jumps", jump_times.size(), 1);
        if (jump_times.size() >= 1) chk("sc1_jump_cycle", jump_times[0], k + 3);
        chk("sc1_pend", int'(pend_cnt), 0);

        // five jumps two cycles apart: queue saturates, one dropped
        jump_times.delete();
        send(8'h4A, 1, 1, 0, k0);
        for (int i = 1; i < 5; i++) send(8'h4A, 1, 1, 0, k);
        wait_cyc(k0 + 10);
        chk("sc2_pend_full", int'(pend_cnt), 3);
        chk("sc2_issued", jump_times.size(), 1);
        chk("sc2_err", int'(err_cnt), 1);
        wait_cyc(k0 + 40);
        chk("sc2_jumps", jump_times.size(), 4);
        if (jump_times.size() >= 1) chk("sc2_first", jump_times[0], k0 + 3);
        for (int i = 1; i < jump_times.size(); i++)
            chk("sc2_spacing", jump_times[i] - jump_times[i-1], HOLDOFF);
        chk("sc2_pend_end", int'(pend_cnt), 0);

        // pause holds the queue, unpause releases it
        jump_times.delete();
        send(8'h50, 1, 5, 0, k);
        send(8'h4A, 1, 5, 0, k);
        chk("sc3_paused", int'(paused), 1);
        chk("sc3_queued", int'(pend_cnt), 1);
        chk("sc3_no_jump", jump_times.size(), 0);
        send(8'h50, 1, 5, 0, k);
        wait_cyc(k + 12);
        chk("sc3_jumps", jump_times.size(), 1);
        if (jump_times.size() >= 1) chk("sc3_jump_cycle", jump_times[0], k + 3);
        chk("sc3_unpaused", int'(paused), 0);

        // restart during holdoff with two queued, then an immediate jump
        jump_times.delete();
        restart_times.delete();
        send(8'h50, 1, 1, 0, ka);
        send(8'h4A, 1, 1, 0, k);
        send(8'h4A, 1, 1, 0, k);
        send(8'h50, 1, 1, 0, k);
        send(8'h4A, 1, 1, 0, k);
        send(8'h52, 1, 1, 0, k);
        wait_cyc(ka + 12);
        chk("sc4_restarts", restart_times.size(), 1);
        if (restart_times.size() >= 1) chk("sc4_restart_cycle", restart_times[0], ka + 12);
        chk("sc4_pend_clr", int'(pend_cnt), 0);
        chk("sc4_paused_clr", int'(paused), 0);
        send(8'h4A, 1, 1, 0, k4);
        wait_cyc(k4 + 14);
        chk("sc4_jumps", jump_times.size(), 2);
        if (jump_times.size() >= 2) chk("sc4_fast_jump", jump_times[1], k4 + 3);

        // error counter saturation
        do_reset(2);
        idle(1);
        send(8'h41, 1, 1, 0, k);
        wait_cyc(k + 3);
        chk("sc5_err_first", int'(err_cnt), 1);
        send(8'h00, 1, 1, 0, k);
        wait_cyc(k + 3);
        chk("sc5_err_null", int'(err_cnt), 1);
        for (int i = 0; i < 255; i++) begin
            send(8'h41, 1, 1, 0, k);
            if (i == 252) begin
                wait_cyc(k + 2);
                chk("sc5_err_254", int'(err_cnt), 254);
            end
        end
        wait_cyc(k + 4);
        chk("sc5_err_sat", int'(err_cnt), 255);
`else
        // framing: bare command ignored, framed command accepted, timeout counted
        jump_times.delete();
        send(8'h4A, 1, 1, 0, k);
        wait_cyc(k + 10);
        chk("fr_bare_ignored", jump_times.size(), 0);
        chk("fr_bare_err", int'(err_cnt), 0);
        send(8'h23, 1, 1, 0, k);
        send(8'h4A, 1, 1, 0, k);
        wait_cyc(k + 10);
        chk("fr_jumps", jump_times.size(), 1);
        if (jump_times.size() >= 1) chk("fr_jump_cycle", jump_times[0], k + 3);
        send(8'h23, 1, 1, 0, k);
        idle(21);
        chk("fr_timeout_err", int'(err_cnt), 1);
        send(8'h4A, 1, 1, 0, k);
        wait_cyc(k + 10);
        chk("fr_back_to_hdr", jump_times.size(), 1);
        chk("fr_err_stable", int'(err_cnt), 1);
`endif

        // randomized traffic with occasional resets (sometimes with rx_done held high)
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            case (r)
                0, 1, 2, 3: b = 8'h4A;
                4:          b = 8'h6A;
                5:          b = 8'h31;
                6:          b = 8'h52;
                7:          b = 8'h72;
                8:          b = 8'h50;
                9:          b = 8'h70;
                10:         b = 8'h00;
                11, 12, 13: b = 8'h23;
                default:    b = 8'($urandom);
            endcase
            if ($urandom_range(0, 59) == 0) begin
                rx_done = 1'($urandom_range(0, 1));
                rx_data = b;
                do_reset($urandom_range(1, 3));
                idle($urandom_range(1, 3));
                rx_done = 1'b0;
                idle(1);
            end
            send(b, $urandom_range(1, 4), $urandom_range(1, 6), 1'b1, k);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
